seg_scan_mux: RTL and testbench
===============================

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000, clk cycles each digit is driven (1 kHz per digit at 100 MHz); legal range >= 2.
REQ-002 SHALL have parameter GAP_CYC, default 16, all-anodes-off cycles before each digit (anti-ghosting); legal range >= 1.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port value_in  input  16  four hex digits; digit k = value_in[4k+3:4k], digit 0 rightmost.
REQ-006 SHALL have port dp_in  input  4  decimal-point enables; bit k belongs to digit k.
REQ-007 SHALL have port load  input  1  one-cycle strobe capturing value_in/dp_in.
REQ-008 SHALL have port nibble  output  4  hex code of the active digit, fed to the downstream segment decoder.
REQ-009 SHALL have port an  output  4  active-low anode selects; an[k]=0 lights digit k.
REQ-010 SHALL have port dp_n  output  1  active-low decimal point of the active digit.
REQ-011 SHALL have port pending  output  1  high while a loaded value awaits the next frame boundary.
REQ-012 SHALL have port frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 SHALL hold a shadow register (16+4 bits) and a display register (16+4 bits); load writes value_in/dp_in into shadow and sets pending on the same edge.
REQ-014 SHALL let the last load win when several loads arrive before a frame boundary.
REQ-015 SHALL run FSM GAP -> DRIVE -> GAP ...; GAP lasts exactly GAP_CYC cycles, DRIVE exactly CLK_DIV cycles, counted by one down/up counter sized $clog2 of the larger.
REQ-016 SHALL in GAP drive an=4'b1111 and dp_n=1; nibble already presents the upcoming digit.
REQ-017 SHALL in DRIVE drive an = ~(4'b0001 << idx), nibble = display digit idx, dp_n = ~display dp[idx].
REQ-018 SHALL on the DRIVE->GAP edge increment idx modulo 4 (3 wraps to 0).
REQ-019 SHALL on the edge where idx wraps 3->0 (frame boundary): pulse frame_tick for the following cycle; if pending, copy shadow to display and clear pending.
REQ-020 SHALL, when load coincides with a frame boundary edge, transfer the old shadow to display, capture the new value into shadow and leave pending=1.
REQ-021 SHALL give a frame period of exactly 4*(CLK_DIV+GAP_CYC) cycles, and display content SHALL never change mid-frame (no tearing).
REQ-022 SHALL keep nibble and an purely registered (no combinational path from inputs to outputs).

Reset
REQ-023 SHALL, while rst_n=0 regardless of clk, force an=4'b1111, dp_n=1, nibble=0, pending=0, frame_tick=0, idx=0, FSM=GAP, counter=0, shadow=0, display=0.
REQ-024 SHALL, after rst_n deasserts mid-frame or mid-load, restart with GAP_CYC GAP cycles then digit 0; a load during reset is discarded.

Configuration
REQ-025 SHALL support macro SEG_LZB_EN: when defined, digits 3..1 whose nibble and all more-significant nibbles are zero keep an[k]=1 and dp_n=1 during their DRIVE slot (timing unchanged); digit 0 is never blanked.
REQ-026 SHALL, without SEG_LZB_EN, drive every digit including leading zeros; the blanking logic is absent.

Verification (CLK_DIV=4, GAP_CYC=1)
REQ-027 Reset release -> an=1111 for 1 cycle, then an=1110 4 cycles, 1111 1 cycle, 1101 4 cycles ...; frame_tick every 20 cycles.
REQ-028 load value_in=16'h12AF, dp_in=4'b0100 mid-frame -> pending=1 until boundary; next frame nibble sequence F,A,2,1 with dp_n=0 only while an=1011.
REQ-029 Two loads 16'h1111 then 16'h2222 in one frame -> next frame shows 2222; 1111 never displayed.
REQ-030 load 16'h5555 on the frame-boundary edge while 16'h4444 pending -> next frame shows 4444, pending stays 1, frame after shows 5555.
REQ-031 SEG_LZB_EN defined, value 16'h0007 -> an=1110 in digit-0 slot, an=1111 in slots 1-3; value 16'h0000 -> only digit 0 lit showing 0.
REQ-032 rst_n pulsed low mid-DRIVE of digit 2 -> outputs immediately at reset values; restart at digit 0 with display=0.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed 7-segment scanner with double-buffered frame update.
// Define SEG_LZB_EN to blank leading-zero digits 3..1.
module seg_scan_mux #(
    parameter int CLK_DIV = 100000,
    parameter int GAP_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic        pending,
    output logic        frame_tick
);

    localparam int MAXC = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] DRV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic {
        GAP   = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    idx, idx_nx;
    logic          boundary;
    logic [15:0]   sh_val, disp_val, disp_val_nx;
    logic [3:0]    sh_dp, disp_dp, disp_dp_nx;
    logic [3:0]    an_nx, nibble_nx;
    logic          dp_n_nx, pending_nx;
`ifdef SEG_LZB_EN
    logic [3:0]    blank;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        boundary = 1'b0;
        case (state)
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nx = DRIVE;
                    cnt_nx   = '0;
                end
            end
            DRIVE: begin
                if (cnt == DRV_LAST) begin
                    state_nx = GAP;
                    cnt_nx   = '0;
                    idx_nx   = idx + 2'd1;
                    boundary = (idx == 2'd3);
                end
            end
            default: begin
                state_nx = GAP;
                cnt_nx   = '0;
            end
        endcase
    end

    // Display only changes at the frame boundary, so a frame never tears.
    always_comb begin
        disp_val_nx = disp_val;
        disp_dp_nx  = disp_dp;
        pending_nx  = pending;
        if (boundary && pending) begin
            disp_val_nx = sh_val;
            disp_dp_nx  = sh_dp;
            pending_nx  = 1'b0;
        end
        if (load) begin
            pending_nx = 1'b1;
        end
    end

`ifdef SEG_LZB_EN
    always_comb begin
        blank    = 4'b0000;
        blank[3] = (disp_val_nx[15:12] == 4'h0);
        blank[2] = blank[3] && (disp_val_nx[11:8] == 4'h0);
        blank[1] = blank[2] && (disp_val_nx[7:4] == 4'h0);
    end
`endif

    // Outputs are computed from next-state values and then registered.
    always_comb begin
        nibble_nx = disp_val_nx[{idx_nx, 2'b00} +: 4];
        an_nx     = 4'b1111;
        dp_n_nx   = 1'b1;
        if (state_nx == DRIVE) begin
            an_nx   = ~(4'b0001 << idx_nx);
            dp_n_nx = ~disp_dp_nx[idx_nx];
`ifdef SEG_LZB_EN
            if (blank[idx_nx]) begin
                an_nx   = 4'b1111;
                dp_n_nx = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GAP;
            cnt        <= '0;
            idx        <= 2'd0;
            sh_val     <= 16'h0000;
            sh_dp      <= 4'h0;
            disp_val   <= 16'h0000;
            disp_dp    <= 4'h0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            nibble     <= 4'h0;
            an         <= 4'b1111;
            dp_n       <= 1'b1;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            disp_val   <= disp_val_nx;
            disp_dp    <= disp_dp_nx;
            pending    <= pending_nx;
            frame_tick <= boundary;
            nibble     <= nibble_nx;
            an         <= an_nx;
            dp_n       <= dp_n_nx;
            if (load) begin
                sh_val <= value_in;
                sh_dp  <= dp_in;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized self-checking bench for seg_scan_mux (CLK_DIV=4, GAP_CYC=1).
// Reference model derives outputs from cycle position within the frame.
module tb_seg_scan_mux;

    localparam int DIV   = 4;
    localparam int GAPC  = 1;
    localparam int SLOT  = DIV + GAPC;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        load = 1'b0;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        dp_n;
    logic        pending;
    logic        frame_tick;

    int npass = 0;
    int ntotal = 0;

    int          t;
    logic [15:0] m_sh, m_disp;
    logic [3:0]  m_shdp, m_dpd;
    logic        m_pend;

    seg_scan_mux #(.CLK_DIV(DIV), .GAP_CYC(GAPC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .value_in(value_in),
        .dp_in(dp_in),
        .load(load),
        .nibble(nibble),
        .an(an),
        .dp_n(dp_n),
        .pending(pending),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] outs();
        return {an, nibble, dp_n, pending, frame_tick};
    endfunction

    // Expected outputs for cycle t after reset release.
    function automatic logic [10:0] exp_out();
        int p, k, o;
        logic [3:0] a, nb;
        logic d;
        p  = t % FRAME;
        k  = p / SLOT;
        o  = p % SLOT;
        nb = m_disp[k*4 +: 4];
        a  = 4'hF;
        d  = 1'b1;
        if (o >= GAPC) begin
            a[k] = 1'b0;
            d    = ~m_dpd[k];
`ifdef SEG_LZB_EN
            if (k > 0 && (m_disp >> (4*k)) == 16'h0) begin
                a = 4'hF;
                d = 1'b1;
            end
`endif
        end
        return {a, nb, d, m_pend, (p == 0 && t > 0)};
    endfunction

    task automatic model_reset();
        t      = 0;
        m_sh   = 16'h0;
        m_disp = 16'h0;
        m_shdp = 4'h0;
        m_dpd  = 4'h0;
        m_pend = 1'b0;
    endtask

    // Drive inputs for one clock and advance the model across that edge.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
        load     = ld;
        value_in = v;
        dp_in    = d;
        if ((t + 1) % FRAME == 0 && m_pend) begin
            m_disp = m_sh;
            m_dpd  = m_shdp;
            m_pend = 1'b0;
        end
        if (ld) begin
            m_sh   = v;
            m_shdp = d;
            m_pend = 1'b1;
        end
        t++;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b1;
        value_in = 16'hBEEF;
        dp_in = 4'hF;
        repeat (3) @(negedge clk);
        ntotal++;
        if (outs() !== 11'b1111_0000_1_0_0) begin
            $display("FAIL reset got %b exp %b", outs(), 11'b1111_0000_1_0_0);
        end else npass++;
        load = 1'b0;
        release_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            ntotal++;
            if (outs() !== exp_out()) begin
                $display("FAIL scan t=%0d got %b exp %b", t, outs(), exp_out());
            end else npass++;
            step(1'b0, 16'h0, 4'h0);
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < 3 * FRAME; i++) begin
            ntotal++;
            if (outs() !== exp_out()) begin
                $display("FAIL load t=%0d got %b exp %b", t, outs(), exp_out());
            end else npass++;
            if (i == 7) step(1'b1, 16'h12AF, 4'b0100);
            else step(1'b0, 16'h0, 4'h0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3 * FRAME; i++) begin
            ntotal++;
            if (outs() !== exp_out()) begin
                $display("FAIL b2b t=%0d got %b exp %b", t, outs(), exp_out());
            end else npass++;
            if (t % FRAME == 3 && i < FRAME) step(1'b1, 16'h1111, 4'h1);
            else if (t % FRAME == 9 && i < FRAME) step(1'b1, 16'h2222, 4'h2);
            else step(1'b0, 16'h0, 4'h0);
        end
    endtask

    task automatic test_boundary_load();
        int phase;
        phase = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            ntotal++;
            if (outs() !== exp_out()) begin
                $display("FAIL bnd t=%0d got %b exp %b", t, outs(), exp_out());
            end else npass++;
            if (phase == 0 && t % FRAME == 6) begin
                step(1'b1, 16'h4444, 4'h0);
                phase = 1;
            end else if (phase == 1 && (t + 1) % FRAME == 0) begin
                step(1'b1, 16'h5555, 4'h8);
                phase = 2;
            end else step(1'b0, 16'h0, 4'h0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ntotal++;
            if (outs() !== exp_out()) begin
                $display("FAIL rand t=%0d got %b exp %b", t, outs(), exp_out());
            end else npass++;
            if ($urandom_range(0, 9) == 0)
                step(1'b1, 16'($urandom), 4'($urandom));
            else step(1'b0, 16'($urandom), 4'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        while (t % FRAME != 2 * SLOT + GAPC + 1) step(1'b0, 16'h0, 4'h0);
        #2;
        rst_n    = 1'b0;
        load     = 1'b1;
        value_in = 16'h9876;
        #1;
        ntotal++;
        if (outs() !== 11'b1111_0000_1_0_0) begin
            $display("FAIL rstmid got %b exp %b", outs(), 11'b1111_0000_1_0_0);
        end else npass++;
        repeat (2) @(negedge clk);
        load = 1'b0;
        release_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            ntotal++;
            if (outs() !== exp_out()) begin
                $display("FAIL rstrun t=%0d got %b exp %b", t, outs(), exp_out());
            end else npass++;
            step(1'b0, 16'h0, 4'h0);
        end
    endtask

`ifdef SEG_LZB_EN
    task automatic test_lzb();
        logic [15:0] vals [4];
        vals[0] = 16'h0007;
        vals[1] = 16'h0000;
        vals[2] = 16'h0300;
        vals[3] = 16'h1000;
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 2 * FRAME; i++) begin
                ntotal++;
                if (outs() !== exp_out()) begin
                    $display("FAIL lzb t=%0d got %b exp %b", t, outs(), exp_out());
                end else npass++;
                if (i == 2) step(1'b1, vals[v], 4'hF);
                else step(1'b0, 16'h0, 4'h0);
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_load();
        test_back_to_back();
        test_boundary_load();
        test_random();
        test_reset_mid();
`ifdef SEG_LZB_EN
        test_lzb();
`endif
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
